// File: rtl/pwm_mixer.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_mixer
//  Description : N-channel quadrature encoder to PWM mixer. Each channel has
//                a debounce stage, an edge decoder and a level register. A
//                shared period counter drives every channel's PWM output.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_mixer #(
    parameter int NUM_CH      = 3,
    parameter int WIDTH       = 8,
    parameter int DB_LEN      = 8,
    parameter int STEP        = 1,
    parameter int SATURATE    = 1,
    parameter int RESET_LEVEL = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       enc_a,
    input  logic [NUM_CH-1:0]       enc_b,
    output logic [NUM_CH-1:0]       pwm_out,
    output logic [NUM_CH*WIDTH-1:0] level_out,
    output logic                    period_start
);

    localparam logic [WIDTH:0]   c_STEP        = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] c_RESET_LEVEL = WIDTH'(RESET_LEVEL);
    localparam logic [WIDTH-1:0] c_MAX         = {WIDTH{1'b1}};

    logic [WIDTH-1:0] r_cnt;
    logic             r_period_start;
    logic             w_wrap;

    // Duty registers capture on the edge where the counter rolls back to 0.
    assign w_wrap = (r_cnt == c_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt          <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_cnt          <= r_cnt + 1'b1;
            r_period_start <= (r_cnt == '0);
        end
    end

    assign period_start = r_period_start;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DB_LEN-1:0] r_hist_a;
        logic [DB_LEN-1:0] r_hist_b;
        logic              r_db_a;
        logic              r_db_b;
        logic              r_prev_a;
        logic              r_prev_b;
        logic [WIDTH-1:0]  r_level;
        logic [WIDTH-1:0]  r_duty;
        logic              r_pwm;
        logic [WIDTH:0]    w_sum;
        logic [WIDTH:0]    w_diff;
        logic [WIDTH-1:0]  w_level_nxt;

        // The extra MSB of the sum/difference flags overflow or borrow.
        always_comb begin
            w_sum       = {1'b0, r_level} + c_STEP;
            w_diff      = {1'b0, r_level} - c_STEP;
            w_level_nxt = r_level;
            if ((r_db_a != r_prev_a) && (r_db_b == r_prev_b)) begin
                if (r_db_a != r_db_b) begin
                    w_level_nxt = ((SATURATE != 0) && w_sum[WIDTH]) ? c_MAX : w_sum[WIDTH-1:0];
                end else begin
                    w_level_nxt = ((SATURATE != 0) && w_diff[WIDTH]) ? '0 : w_diff[WIDTH-1:0];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_hist_a <= '0;
                r_hist_b <= '0;
                r_db_a   <= 1'b0;
                r_db_b   <= 1'b0;
                r_prev_a <= 1'b0;
                r_prev_b <= 1'b0;
                r_level  <= c_RESET_LEVEL;
                r_duty   <= c_RESET_LEVEL;
                r_pwm    <= 1'b0;
            end else begin
                r_hist_a <= {r_hist_a[DB_LEN-2:0], enc_a[i]};
                r_hist_b <= {r_hist_b[DB_LEN-2:0], enc_b[i]};
                if (&r_hist_a)       r_db_a <= 1'b1;
                else if (~|r_hist_a) r_db_a <= 1'b0;
                if (&r_hist_b)       r_db_b <= 1'b1;
                else if (~|r_hist_b) r_db_b <= 1'b0;
                r_prev_a <= r_db_a;
                r_prev_b <= r_db_b;
                r_level  <= w_level_nxt;
                if (w_wrap) r_duty <= r_level;
                r_pwm    <= (r_cnt < r_duty);
            end
        end

        assign pwm_out[i]                 = r_pwm;
        assign level_out[i*WIDTH +: WIDTH] = r_level;
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_mixer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_mixer
//  Description : Randomized scoreboard bench for pwm_mixer, one saturating
//                and one wrapping instance sharing the same encoder inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_mixer;

    localparam int NCH    = 3;
    localparam int W      = 8;
    localparam int DBL    = 8;
    localparam int RL     = 128;
    localparam int STEP_S = 16;
    localparam int STEP_W = 48;
    localparam int PERIOD = 256;

    typedef struct {
        logic [NCH*W-1:0] lvl_s;
        logic [NCH*W-1:0] lvl_w;
        logic [NCH-1:0]   pwm_s;
        logic [NCH-1:0]   pwm_w;
        logic             ps;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [NCH-1:0]   ea;
    logic [NCH-1:0]   eb;
    logic [NCH-1:0]   pwm_s, pwm_w;
    logic [NCH*W-1:0] lvl_s, lvl_w;
    logic             ps_s, ps_w;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cycle = 0;

    // Reference state: levels, duty and debounce expressed as run lengths.
    int   lvl  [2][NCH];
    int   duty [2][NCH];
    int   run  [2*NCH];
    bit   last [2*NCH];
    bit   db   [2*NCH];
    int   pend [NCH];
    int   n_edge;

    always #5 clk = ~clk;

    pwm_mixer #(.NUM_CH(NCH), .WIDTH(W), .DB_LEN(DBL), .STEP(STEP_S),
                .SATURATE(1), .RESET_LEVEL(RL)) dut_s (
        .clk(clk), .reset(rst), .enc_a(ea), .enc_b(eb),
        .pwm_out(pwm_s), .level_out(lvl_s), .period_start(ps_s));

    pwm_mixer #(.NUM_CH(NCH), .WIDTH(W), .DB_LEN(DBL), .STEP(STEP_W),
                .SATURATE(0), .RESET_LEVEL(RL)) dut_w (
        .clk(clk), .reset(rst), .enc_a(ea), .enc_b(eb),
        .pwm_out(pwm_w), .level_out(lvl_w), .period_start(ps_w));

    function automatic int step_level(int v, int dir, int stp, bit sat);
        int r;
        r = v + dir * stp;
        if (sat) begin
            if (r > PERIOD - 1) r = PERIOD - 1;
            if (r < 0) r = 0;
        end else begin
            r = ((r % PERIOD) + PERIOD) % PERIOD;
        end
        return r;
    endfunction

    // Predicts the outputs visible just after the next rising edge.
    task automatic model_edge();
        exp_t e;
        bit   nd [2*NCH];
        bit   x;
        int   pos;
        if (rst) begin
            n_edge = 0;
            for (int s = 0; s < 2; s++)
                for (int c = 0; c < NCH; c++) begin
                    lvl[s][c]  = RL;
                    duty[s][c] = RL;
                end
            for (int k = 0; k < 2*NCH; k++) begin
                run[k] = DBL; last[k] = 1'b0; db[k] = 1'b0;
            end
            for (int c = 0; c < NCH; c++) pend[c] = 0;
            e.pwm_s = '0;
            e.pwm_w = '0;
            e.ps    = 1'b0;
        end else begin
            n_edge++;
            pos  = (n_edge - 1) % PERIOD;
            e.ps = (pos == 0);
            for (int c = 0; c < NCH; c++) begin
                e.pwm_s[c] = (pos < duty[0][c]);
                e.pwm_w[c] = (pos < duty[1][c]);
            end
            if (n_edge % PERIOD == 0)
                for (int s = 0; s < 2; s++)
                    for (int c = 0; c < NCH; c++) duty[s][c] = lvl[s][c];
            for (int c = 0; c < NCH; c++) begin
                if (pend[c] != 0) begin
                    lvl[0][c] = step_level(lvl[0][c], pend[c], STEP_S, 1'b1);
                    lvl[1][c] = step_level(lvl[1][c], pend[c], STEP_W, 1'b0);
                end
                pend[c] = 0;
            end
            for (int k = 0; k < 2*NCH; k++) begin
                nd[k] = (run[k] >= DBL) ? last[k] : db[k];
                x = (k < NCH) ? ea[k] : eb[k - NCH];
                if (x == last[k]) begin
                    if (run[k] < DBL) run[k]++;
                end else begin
                    last[k] = x;
                    run[k]  = 1;
                end
            end
            for (int c = 0; c < NCH; c++) begin
                if ((nd[c] != db[c]) && (nd[c+NCH] == db[c+NCH]))
                    pend[c] = (nd[c] != nd[c+NCH]) ? 1 : -1;
            end
            for (int k = 0; k < 2*NCH; k++) db[k] = nd[k];
        end
        for (int c = 0; c < NCH; c++) begin
            e.lvl_s[c*W +: W] = W'(lvl[0][c]);
            e.lvl_w[c*W +: W] = W'(lvl[1][c]);
        end
        q.push_back(e);
    endtask

    task automatic cyc(input int k);
        repeat (k) begin
            model_edge();
            @(negedge clk);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", nm, cycle, got, exp);
        end
    endtask

    // Monitor: every clock edge presents a new output word.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("level_sat",    32'(lvl_s), 32'(e.lvl_s));
                chk("level_wrap",   32'(lvl_w), 32'(e.lvl_w));
                chk("pwm_sat",      32'(pwm_s), 32'(e.pwm_s));
                chk("pwm_wrap",     32'(pwm_w), 32'(e.pwm_w));
                chk("period_start", 32'(ps_s),  32'(e.ps));
                chk("period_start_w", 32'(ps_w), 32'(e.ps));
            end
        end
    end

    initial begin
        int c, k, len;
        rst = 1'b1;
        ea  = '0;
        eb  = '0;
        cyc(3);
        rst = 1'b0;
        cyc(600);
        for (int seg = 0; seg < 1800; seg++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                cyc($urandom_range(1, 3));
                rst = 1'b0;
            end
            c = $urandom_range(0, NCH - 1);
            k = $urandom_range(0, 9);
            if (k < 6)      ea[c] = ~ea[c];
            else if (k < 8) eb[c] = ~eb[c];
            else begin
                ea[c] = ~ea[c];
                eb[c] = ~eb[c];
            end
            if ($urandom_range(0, 3) == 0) len = $urandom_range(1, DBL - 1);
            else                           len = $urandom_range(DBL, DBL + 12);
            cyc(len);
        end
        cyc(600);
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
